memory_stage: RTL and testbench

- Pipeline stage after Execute. Consumes Execute's result, destination index, control word and write-enable.
- Performs LOAD/STORE accesses to data memory over a req/ack handshake that tolerates wait states.
- Registers the writeback bundle, forwards it to Decode, and stalls upstream while an access is outstanding.

---
 rtl/memory_stage_pkg.sv | 34 +++
 rtl/memory_stage_if.sv | 31 +++
 rtl/memory_stage_mem_access_fsm.sv | 114 +++++++++++
 rtl/memory_stage.sv | 147 ++++++++++++++
 tb/tb_memory_stage.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_stage_pkg.sv
// -----------------------------------------------------------------------------
// memory_stage_pkg
// Shared definitions for the memory stage: opcode constants (matching the
// Execute stage), the stage state encoding, default widths and a small
// opcode-classification helper.
// -----------------------------------------------------------------------------
package memory_stage_pkg;

  localparam int DATA_W_DEF      = 16;
  localparam int IDX_W_DEF       = 6;
  localparam int MEM_TIMEOUT_DEF = 16;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_SHL   = 4'b0110;
  localparam logic [3:0] OP_SHR   = 4'b0111;
  localparam logic [3:0] OP_MOV   = 4'b1000;
  localparam logic [3:0] OP_LOAD  = 4'b1100;
  localparam logic [3:0] OP_STORE = 4'b1110;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } stage_state_e;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// -----------------------------------------------------------------------------
// memory_stage_if
// Data-memory request/acknowledge bus.
//   mem_req   : request held high until the access completes or is aborted
//   mem_we    : 1 = write
//   mem_addr  : access address
//   mem_wdata : write data (0 for reads)
//   mem_rdata : read data, valid together with mem_ack
//   mem_ack   : access complete
// master = memory stage, slave = data memory.
// -----------------------------------------------------------------------------
interface memory_stage_if #(
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/memory_stage_mem_access_fsm.sv
// -----------------------------------------------------------------------------
// memory_stage_mem_access_fsm
// Owns one data-memory access: state register, request/address holding
// registers, timeout counter and sticky error flag.
//   i_start/i_start_*  : launch an access (honoured only in IDLE)
//   i_mem_ack          : memory completion
//   o_busy             : high while an access is outstanding (ACCESS)
//   o_done             : ACCESS cycle in which ack is seen (combinational)
//   o_timeout          : ACCESS cycle in which the access is abandoned
//   o_mem_*            : request bus drive
//   o_mem_error        : sticky timeout flag, cleared only by reset
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no access outstanding; a new access may start
// ST_ACCESS | request on the bus, waiting for ack or timeout
// -----------------------------------------------------------------------------
module memory_stage_mem_access_fsm
  import memory_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_start_we,
  input  logic [DATA_W-1:0] i_start_addr,
  input  logic [DATA_W-1:0] i_start_wdata,
  input  logic              i_mem_ack,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_error
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  // Last no-ack cycle index before abandoning: the request stays up for
  // exactly MEM_TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
  localparam logic TIMEOUT_EN = (MEM_TIMEOUT > 0);

  stage_state_e      r_state;
  stage_state_e      w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_error;
  logic              w_done;
  logic              w_timeout;
  logic              w_launch;

  assign w_launch = i_start && (r_state == ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (i_mem_ack) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (TIMEOUT_EN && (r_cnt == CNT_LAST)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_launch) begin
        r_cnt       <= '0;
        r_mem_we    <= i_start_we;
        r_mem_addr  <= i_start_addr;
        r_mem_wdata <= i_start_wdata;
      end else if ((r_state == ST_ACCESS) && !i_mem_ack) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_timeout) r_mem_error <= 1'b1;
    end
  end

  assign o_busy      = (r_state == ST_ACCESS);
  assign o_mem_req   = (r_state == ST_ACCESS);
  assign o_done      = w_done;
  assign o_timeout   = w_timeout;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_error = r_mem_error;

endmodule

// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
// Pipeline stage after Execute. Non-memory ops retire one cycle after
// acceptance; LOAD/STORE go through the data-memory handshake and retire on
// ack (or are abandoned on timeout). The writeback bundle is registered and
// forwarded to Decode.
//   clk, rst            : clock, async active-high reset
//   i_valid_in ..       : Execute result bundle (control, result/address,
//                         store data, destination index, write enable)
//   o_stall             : upstream must hold while an access is outstanding
//   mem_if              : data-memory request bus (master side)
//   o_wb_*              : writeback bundle, o_wb_valid is a 1-cycle pulse
//   o_control_out       : registered control word
//   o_result_forward    : same as o_wb_data
//   o_fwd_valid         : o_wb_valid & o_wb_write_enable
//   o_mem_error         : sticky memory timeout flag
// -----------------------------------------------------------------------------
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int IDX_W       = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid_in,
  input  logic [4:0]        i_control_in,
  input  logic [DATA_W-1:0] i_result_in,
  input  logic [DATA_W-1:0] i_store_data,
  input  logic [IDX_W-1:0]  i_dest_index_in,
  input  logic              i_write_enable_in,
  output logic              o_stall,
  memory_stage_if.master    mem_if,
  output logic              o_wb_valid,
  output logic [DATA_W-1:0] o_wb_data,
  output logic [IDX_W-1:0]  o_wb_dest_index,
  output logic              o_wb_write_enable,
  output logic [4:0]        o_control_out,
  output logic [DATA_W-1:0] o_result_forward,
  output logic              o_fwd_valid,
  output logic              o_mem_error
);

  logic [3:0]        w_op;
  logic              w_busy;
  logic              w_accept;
  logic              w_is_mem;
  logic              w_start;
  logic              w_done;
  logic              w_timeout;
  logic [DATA_W-1:0] w_mem_addr;

  logic              r_wb_valid;
  logic [DATA_W-1:0] r_wb_data;
  logic [IDX_W-1:0]  r_wb_dest;
  logic              r_wb_we;
  logic [4:0]        r_ctrl;
  logic [IDX_W-1:0]  r_pend_dest;
  logic [4:0]        r_pend_ctrl;
  logic              r_pend_load;

  assign w_op     = i_control_in[3:0];
  assign w_accept = i_valid_in && !w_busy;
  assign w_is_mem = is_mem_op(w_op);
  assign w_start  = w_accept && w_is_mem;

  memory_stage_mem_access_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .DATA_W      (DATA_W)
  ) u_fsm (
    .clk           (clk),
    .rst           (rst),
    .i_start       (w_start),
    .i_start_we    (w_op == OP_STORE),
    .i_start_addr  (i_result_in),
    .i_start_wdata ((w_op == OP_STORE) ? i_store_data : '0),
    .i_mem_ack     (mem_if.mem_ack),
    .o_busy        (w_busy),
    .o_done        (w_done),
    .o_timeout     (w_timeout),
    .o_mem_req     (mem_if.mem_req),
    .o_mem_we      (mem_if.mem_we),
    .o_mem_addr    (w_mem_addr),
    .o_mem_wdata   (mem_if.mem_wdata),
    .o_mem_error   (o_mem_error)
  );

  assign mem_if.mem_addr = w_mem_addr;

  // Accept happens only in IDLE and done/timeout only in ACCESS, so the
  // branches below never compete for the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid  <= 1'b0;
      r_wb_data   <= '0;
      r_wb_dest   <= '0;
      r_wb_we     <= 1'b0;
      r_ctrl      <= '0;
      r_pend_dest <= '0;
      r_pend_ctrl <= '0;
      r_pend_load <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      if (w_accept && !w_is_mem) begin
        r_ctrl <= i_control_in;
        if (w_op == OP_NOP) begin
          r_wb_we <= 1'b0;
        end else begin
          r_wb_valid <= 1'b1;
          r_wb_data  <= i_result_in;
          r_wb_dest  <= i_dest_index_in;
          r_wb_we    <= i_write_enable_in;
        end
      end
      if (w_start) begin
        r_pend_dest <= i_dest_index_in;
        r_pend_ctrl <= i_control_in;
        r_pend_load <= (w_op == OP_LOAD);
      end
      if (w_done) begin
        r_wb_valid <= 1'b1;
        r_wb_data  <= r_pend_load ? mem_if.mem_rdata : w_mem_addr;
        r_wb_dest  <= r_pend_dest;
        r_wb_we    <= r_pend_load;
        r_ctrl     <= r_pend_ctrl;
      end
      if (w_timeout) begin
        // Abandoned access still retires, but never writes the register file.
        r_wb_valid <= 1'b1;
        r_wb_dest  <= r_pend_dest;
        r_wb_we    <= 1'b0;
        r_ctrl     <= r_pend_ctrl;
      end
    end
  end

  assign o_stall           = w_busy;
  assign o_wb_valid        = r_wb_valid;
  assign o_wb_data         = r_wb_data;
  assign o_wb_dest_index   = r_wb_dest;
  assign o_wb_write_enable = r_wb_we;
  assign o_control_out     = r_ctrl;
  assign o_result_forward  = r_wb_data;
  assign o_fwd_valid       = r_wb_valid && r_wb_we;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam int DW = 16;
  localparam int IW = 6;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [4:0]    control_in;
  logic [DW-1:0] result_in;
  logic [DW-1:0] store_data;
  logic [IW-1:0] dest_in;
  logic          we_in;
  logic          stall;
  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic [IW-1:0] wb_dest;
  logic          wb_we;
  logic [4:0]    control_out;
  logic [DW-1:0] result_forward;
  logic          fwd_valid;
  logic          mem_error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  memory_stage_if #(.DATA_W(DW)) mem_bus ();

  memory_stage #(.MEM_TIMEOUT(TO), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_valid_in        (valid_in),
    .i_control_in      (control_in),
    .i_result_in       (result_in),
    .i_store_data      (store_data),
    .i_dest_index_in   (dest_in),
    .i_write_enable_in (we_in),
    .o_stall           (stall),
    .mem_if            (mem_bus),
    .o_wb_valid        (wb_valid),
    .o_wb_data         (wb_data),
    .o_wb_dest_index   (wb_dest),
    .o_wb_write_enable (wb_we),
    .o_control_out     (control_out),
    .o_result_forward  (result_forward),
    .o_fwd_valid       (fwd_valid),
    .o_mem_error       (mem_error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] c, input logic [DW-1:0] r, input logic [DW-1:0] sd,
                       input logic [IW-1:0] d, input logic w);
    valid_in   = 1'b1;
    control_in = c;
    result_in  = r;
    store_data = sd;
    dest_in    = d;
    we_in      = w;
  endtask

  // Reference model state: sticky error flag.
  logic exp_err;

  initial begin
    int            n;
    int            movs;
    logic [3:0]    op;
    logic [4:0]    c;
    logic [DW-1:0] r, sd, rd;
    logic [IW-1:0] d;
    logic          w;
    int            kind, waits, cycles;
    logic          acked;

    rst = 1'b1; valid_in = 0; control_in = 0; result_in = 0; store_data = 0;
    dest_in = 0; we_in = 0; mem_bus.mem_ack = 0; mem_bus.mem_rdata = 0;
    exp_err = 1'b0;
    #12;
    chk("reset_outs", {stall, mem_bus.mem_req, wb_valid, wb_data, wb_dest, wb_we, control_out,
                       fwd_valid, mem_error}, '0);
    rst = 1'b0;
    tick();

    // Reset during ACCESS
    drive({1'b0, OP_LOAD}, 16'h0040, 16'h0, 6'd1, 1'b0);
    tick();
    valid_in = 0;
    chk("rst_acc_req_up", {mem_bus.mem_req, stall, mem_bus.mem_addr}, {2'b11, 16'h0040});
    #2 rst = 1'b1;
    #1;
    chk("rst_acc_drop", {mem_bus.mem_req, stall, wb_valid, wb_data, wb_dest, wb_we, mem_error}, '0);
    #2 rst = 1'b0;
    tick();
    drive({1'b0, OP_ADD}, 16'h0005, 16'h0, 6'd2, 1'b1);
    tick();
    valid_in = 0;
    chk("rst_acc_add", {wb_valid, wb_data, wb_dest, wb_we}, {1'b1, 16'h0005, 6'd2, 1'b1});

    // ADD back-to-back
    drive({1'b0, OP_ADD}, 16'h1234, 16'h0, 6'd3, 1'b1);
    tick();
    chk("b2b_first", {wb_valid, wb_data, wb_dest, fwd_valid, stall}, {1'b1, 16'h1234, 6'd3, 1'b1, 1'b0});
    drive({1'b1, OP_SUB}, 16'h0000, 16'h0, 6'd4, 1'b1);
    tick();
    valid_in = 0;
    chk("b2b_second", {wb_valid, wb_data, wb_dest, fwd_valid, stall, control_out},
        {1'b1, 16'h0000, 6'd4, 1'b1, 1'b0, 1'b1, OP_SUB});
    tick();
    chk("b2b_pulse_end", {wb_valid, wb_data, wb_dest}, {1'b0, 16'h0000, 6'd4});

    // NOP
    drive({1'b1, OP_NOP}, 16'hFFFF, 16'h0, 6'd9, 1'b1);
    tick();
    valid_in = 0;
    chk("nop", {wb_valid, wb_we, control_out, wb_data}, {1'b0, 1'b0, 1'b1, OP_NOP, 16'h0000});

    // LOAD with 3 wait states
    drive({1'b0, OP_LOAD}, 16'h0020, 16'h0, 6'd5, 1'b0);
    tick();
    valid_in = 0;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      if (stall === 1'b1) n++;
      chk("ld3_hold", {mem_bus.mem_req, mem_bus.mem_addr, mem_bus.mem_we, wb_valid}, {1'b1, 16'h0020, 2'b00});
      if (k == 3) begin mem_bus.mem_ack = 1; mem_bus.mem_rdata = 16'hBEEF; end
      tick();
    end
    mem_bus.mem_ack = 0;
    chk("ld3_stall_cycles", n, 4);
    chk("ld3_wb", {wb_valid, wb_data, wb_dest, wb_we, fwd_valid, stall, mem_bus.mem_req, control_out},
        {1'b1, 16'hBEEF, 6'd5, 1'b1, 1'b1, 2'b00, 1'b0, OP_LOAD});

    // STORE zero wait
    drive({1'b0, OP_STORE}, 16'h0010, 16'hA5A5, 6'd6, 1'b1);
    tick();
    valid_in = 0;
    chk("st_req", {mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata, wb_valid},
        {2'b11, 16'h0010, 16'hA5A5, 1'b0});
    mem_bus.mem_ack = 1;
    tick();
    mem_bus.mem_ack = 0;
    chk("st_wb", {wb_valid, wb_we, fwd_valid, wb_data, mem_bus.mem_req}, {3'b100, 16'h0010, 1'b0});

    // Timeout
    drive({1'b0, OP_LOAD}, 16'h0030, 16'h0, 6'd7, 1'b0);
    tick();
    valid_in = 0;
    n = 0;
    while (mem_bus.mem_req === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("to_req_cycles", n, TO);
    exp_err = 1'b1;
    chk("to_wb", {wb_valid, wb_we, fwd_valid, mem_error, stall, wb_dest}, {5'b10010, 6'd7});
    mem_bus.mem_ack = 1; mem_bus.mem_rdata = 16'h4444;
    tick();
    mem_bus.mem_ack = 0;
    chk("to_late_ack", {wb_valid, stall, mem_bus.mem_req, mem_error}, 4'b0001);
    tick();
    chk("to_sticky", mem_error, 1'b1);

    // Stall hold: MOV presented throughout an outstanding LOAD
    drive({1'b0, OP_LOAD}, 16'h0050, 16'h0, 6'd8, 1'b0);
    tick();
    drive({1'b0, OP_MOV}, 16'h7777, 16'h0, 6'd9, 1'b1);
    chk("hold_c0", {stall, wb_valid}, 2'b10);
    tick();
    chk("hold_c1", {stall, wb_valid}, 2'b10);
    mem_bus.mem_ack = 1; mem_bus.mem_rdata = 16'h1357;
    tick();
    mem_bus.mem_ack = 0;
    chk("hold_load_ret", {wb_valid, wb_data, wb_dest, stall}, {1'b1, 16'h1357, 6'd8, 1'b0});
    movs = 0;
    tick();
    valid_in = 0;
    if (wb_valid === 1'b1 && wb_data === 16'h7777) movs++;
    chk("hold_mov_ret", {wb_valid, wb_data, wb_dest, wb_we}, {1'b1, 16'h7777, 6'd9, 1'b1});
    tick();
    if (wb_valid === 1'b1) movs++;
    chk("hold_mov_once", movs, 1);

    // Randomized instruction stream against the reference model
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 4);
      r  = DW'($urandom);
      sd = DW'($urandom);
      d  = IW'($urandom);
      w  = 1'($urandom);
      if (kind == 0) op = OP_NOP;
      else if (kind == 2) op = OP_LOAD;
      else if (kind == 3) op = OP_STORE;
      else begin
        op = 4'($urandom_range(1, 15));
        if (op == OP_LOAD || op == OP_STORE) op = OP_MOV;
      end
      c = {1'($urandom), op};
      drive(c, r, sd, d, w);
      tick();
      valid_in = 0;
      if (op == OP_NOP) begin
        chk("rnd_nop", {wb_valid, wb_we, control_out}, {2'b00, c});
      end else if (op != OP_LOAD && op != OP_STORE) begin
        chk("rnd_alu", {wb_valid, wb_data, wb_dest, wb_we, fwd_valid, control_out, result_forward},
            {1'b1, r, d, w, w, c, r});
      end else begin
        waits  = $urandom_range(0, 5);
        acked  = (waits < TO);
        cycles = acked ? waits + 1 : TO;
        rd     = DW'($urandom);
        for (int k = 0; k < cycles; k++) begin
          chk("rnd_mem_bus", {mem_bus.mem_req, stall, mem_bus.mem_addr, mem_bus.mem_we,
                              mem_bus.mem_wdata, wb_valid},
              {2'b11, r, (op == OP_STORE), (op == OP_STORE) ? sd : DW'(0), 1'b0});
          if (acked && k == waits) begin mem_bus.mem_ack = 1; mem_bus.mem_rdata = rd; end
          tick();
          mem_bus.mem_ack = 0;
        end
        if (!acked) exp_err = 1'b1;
        if (!acked)
          chk("rnd_timeout", {wb_valid, wb_we, wb_dest, control_out, mem_bus.mem_req, stall},
              {2'b10, d, c, 2'b00});
        else if (op == OP_LOAD)
          chk("rnd_load", {wb_valid, wb_data, wb_we, wb_dest, fwd_valid, control_out, mem_bus.mem_req},
              {1'b1, rd, 1'b1, d, 1'b1, c, 1'b0});
        else
          chk("rnd_store", {wb_valid, wb_data, wb_we, wb_dest, fwd_valid, mem_bus.mem_req},
              {1'b1, r, 1'b0, d, 2'b00});
      end
      chk("rnd_err", mem_error, exp_err);
      if ($urandom_range(0, 2) == 0) begin
        mem_bus.mem_ack = 1'($urandom);
        tick();
        mem_bus.mem_ack = 0;
        chk("rnd_idle", {wb_valid, stall, mem_bus.mem_req}, 3'b000);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
